// File: rtl/shift_frame_ctrl_if.sv
// Parallel-side handshake bundle for shift_frame_ctrl: the tx word going in
// and the received word (with its parity flag) coming back out.
interface shift_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_perr;

  // producer/consumer side
  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, rx_perr
  );

  // sequencer side
  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, rx_perr
  );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Serial frame sequencer: accepts a parallel word, shifts it out MSB first on
// so while capturing the same number of bits from si, then presents the
// received word with a one-cycle rx_valid strobe. A GAP-cycle idle period is
// forced after every frame.
// Optional build macro SHIFT_FRAME_PARITY_EN appends one even-parity bit to
// each frame and checks the received parity bit into rx_perr.
module shift_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  shift_frame_ctrl_if.slave bus,
  input  logic              si,
  output logic              so,
  output logic              frame,
  output logic              busy
);

`ifdef SHIFT_FRAME_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif
  localparam int CW = $clog2(LEN + 1);
  localparam int GW = $clog2(GAP + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_S} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_perr;

`ifdef SHIFT_FRAME_PARITY_EN
  logic             tx_par;
`endif

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  // next-state: a frame is LEN shift cycles, then GAP idle cycles if any
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.tx_valid) nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) nxt = (GAP > 0) ? GAP_S : IDLE;
      GAP_S:   if (gcnt == GAP_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs decoded from state; ready is held low while reset is asserted
  always_comb begin
    bus.tx_ready = resetn && (state == IDLE);
    frame        = (state == SHIFT);
    busy         = (state != IDLE);
    so           = 1'b0;
    if (state == SHIFT) begin
`ifdef SHIFT_FRAME_PARITY_EN
      // extra trailing cycle carries the parity of the accepted word
      so = (cnt == CNT_LAST) ? tx_par : sreg[WIDTH-1];
`else
      so = sreg[WIDTH-1];
`endif
    end
  end

  // datapath: shift register, counters, received word capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg     <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_perr  <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            sreg   <= bus.tx_data;
            cnt    <= '0;
`ifdef SHIFT_FRAME_PARITY_EN
            tx_par <= ^bus.tx_data;
`endif
          end
        end
        SHIFT: begin
          cnt  <= cnt + 1'b1;
          gcnt <= '0;
`ifdef SHIFT_FRAME_PARITY_EN
          // sreg already holds the full received word in the parity cycle
          if (cnt == CNT_LAST) begin
            rx_data  <= sreg;
            rx_perr  <= si ^ (^sreg);
            rx_valid <= 1'b1;
          end else begin
            sreg <= {sreg[WIDTH-2:0], si};
          end
`else
          sreg <= {sreg[WIDTH-2:0], si};
          if (cnt == CNT_LAST) begin
            rx_data  <= {sreg[WIDTH-2:0], si};
            rx_valid <= 1'b1;
          end
`endif
        end
        GAP_S: gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_perr  = rx_perr;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: a GAP=1 and a GAP=0 instance side by side.
// Inputs are driven and outputs sampled on the falling edge; "cycle n" is
// the period between rising edges n and n+1, the accept edge ending cycle 0.
module tb_shift_frame_ctrl;
  localparam int W = 4;
`ifdef SHIFT_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = W + P;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic si, so, frame, busy;
  logic si0, so0, frame0, busy0;

  shift_frame_ctrl_if #(.WIDTH(W)) b1 ();
  shift_frame_ctrl_if #(.WIDTH(W)) b0 ();

  shift_frame_ctrl #(.WIDTH(W), .GAP(1)) dut (
    .clk(clk), .resetn(resetn), .bus(b1),
    .si(si), .so(so), .frame(frame), .busy(busy)
  );

  shift_frame_ctrl #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(b0),
    .si(si0), .so(so0), .frame(frame0), .busy(busy0)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } rx_t;

  rx_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // expected received word for serial bits s followed by parity bit psi
  function automatic rx_t mk_rx(input logic [W-1:0] s, input logic psi);
    rx_t r;
    r.data = s;
    r.perr = (P == 1) ? (psi ^ (^s)) : 1'b0;
    return r;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b1.tx_valid = 1'($urandom);
      b1.tx_data  = W'($urandom);
      si          = 1'($urandom);
      #1;
      checks++;
      if ({so, frame, busy, b1.tx_ready, b1.rx_valid, b1.rx_data, b1.rx_perr} !== '0) begin
        errors++;
        $display("FAIL reset_outputs act so=%b frame=%b busy=%b rdy=%b rxv=%b rxd=%h perr=%b exp all 0",
                 so, frame, busy, b1.tx_ready, b1.rx_valid, b1.rx_data, b1.rx_perr);
      end
    end
    @(negedge clk);
    b1.tx_valid = 1'b0;
    si = 1'b0;
    resetn = 1'b1;
    #1;
    checks++;
    if ({b1.tx_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release act rdy=%b busy=%b exp rdy=1 busy=0", b1.tx_ready, busy);
    end
  endtask

  // one frame on the GAP=1 instance: word w, serial input s then parity bit psi
  task automatic test_frame(input logic [W-1:0] w, input logic [W-1:0] s, input logic psi);
    logic [W:0] sof, sif;
    rx_t e, got;
    sof = {w, ^w};
    sif = {s, psi};
    @(negedge clk);
    checks++;
    if (b1.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_ready act=%b exp=1", b1.tx_ready);
    end
    b1.tx_valid = 1'b1;
    b1.tx_data  = w;
    exp_q.push_back(mk_rx(s, psi));
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      // changes here must not disturb the frame in flight
      b1.tx_valid = 1'($urandom);
      b1.tx_data  = W'($urandom);
      checks++;
      if ({frame, so, b1.tx_ready} !== {1'b1, sof[W+1-k], 1'b0}) begin
        errors++;
        $display("FAIL frame_shift cyc=%0d act frame=%b so=%b rdy=%b exp frame=1 so=%b rdy=0",
                 k, frame, so, b1.tx_ready, sof[W+1-k]);
      end
      si = sif[W+1-k];
    end
    @(negedge clk);
    b1.tx_valid = 1'b0;
    checks++;
    if ({b1.rx_valid, frame, busy, b1.tx_ready, so} !== 5'b10100) begin
      errors++;
      $display("FAIL frame_gap act rxv=%b frame=%b busy=%b rdy=%b so=%b exp 1,0,1,0,0",
               b1.rx_valid, frame, busy, b1.tx_ready, so);
    end
    got = {b1.rx_data, b1.rx_perr};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL frame_rx act=%h exp=<queue empty>", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL frame_rx act data=%b perr=%b exp data=%b perr=%b", got.data, got.perr, e.data, e.perr);
      end
    end
    @(negedge clk);
    checks++;
    if ({b1.rx_valid, b1.tx_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL frame_idle act rxv=%b rdy=%b busy=%b exp 0,1,0", b1.rx_valid, b1.tx_ready, busy);
    end
  endtask

  // tx_valid held high across two frames on the GAP=1 instance
  task automatic test_back_to_back();
    logic [W-1:0] w1, w2, s1, s2;
    logic [W:0] so1, so2, si1, si2;
    logic p1, p2;
    rx_t e, got;
    w1 = 4'hA; w2 = 4'h5;
    s1 = W'($urandom); s2 = W'($urandom);
    p1 = 1'($urandom); p2 = 1'($urandom);
    so1 = {w1, ^w1}; so2 = {w2, ^w2};
    si1 = {s1, p1};  si2 = {s2, p2};
    @(negedge clk);
    b1.tx_valid = 1'b1;
    b1.tx_data  = w1;
    exp_q.push_back(mk_rx(s1, p1));
    for (int c = 1; c <= 2 * L + 3; c++) begin
      @(negedge clk);
      b1.tx_data = w2;
      if (c <= L) begin
        checks++;
        if ({frame, so, b1.tx_ready} !== {1'b1, so1[W+1-c], 1'b0}) begin
          errors++;
          $display("FAIL b2b_first cyc=%0d act frame=%b so=%b rdy=%b exp 1,%b,0", c, frame, so, b1.tx_ready, so1[W+1-c]);
        end
        si = si1[W+1-c];
      end else if (c == L + 1 || c == 2 * L + 3) begin
        checks++;
        if ({b1.rx_valid, b1.tx_ready, frame} !== 3'b100) begin
          errors++;
          $display("FAIL b2b_rxcyc cyc=%0d act rxv=%b rdy=%b frame=%b exp 1,0,0", c, b1.rx_valid, b1.tx_ready, frame);
        end
        got = {b1.rx_data, b1.rx_perr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_rx cyc=%0d act=%h exp=<queue empty>", c, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL b2b_rx cyc=%0d act data=%b perr=%b exp data=%b perr=%b", c, got.data, got.perr, e.data, e.perr);
          end
        end
        if (c == 2 * L + 3) b1.tx_valid = 1'b0;
      end else if (c == L + 2) begin
        checks++;
        if ({b1.tx_ready, frame} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_reaccept cyc=%0d act rdy=%b frame=%b exp 1,0", c, b1.tx_ready, frame);
        end
        exp_q.push_back(mk_rx(s2, p2));
      end else begin
        checks++;
        if ({frame, so, b1.tx_ready} !== {1'b1, so2[W+1-(c-L-2)], 1'b0}) begin
          errors++;
          $display("FAIL b2b_second cyc=%0d act frame=%b so=%b rdy=%b exp 1,%b,0",
                   c, frame, so, b1.tx_ready, so2[W+1-(c-L-2)]);
        end
        si = si2[W+1-(c-L-2)];
      end
    end
    @(negedge clk);
    checks++;
    if ({b1.rx_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle act rxv=%b busy=%b exp 0,0", b1.rx_valid, busy);
    end
  endtask

  // GAP=0 instance: second accept lands in the rx_valid cycle
  task automatic test_gap0();
    logic [W-1:0] w1, w2, s1, s2;
    logic [W:0] so1, so2, si1, si2;
    logic p1, p2;
    int nframe;
    rx_t e, got;
    w1 = 4'h6; w2 = 4'h9;
    s1 = W'($urandom); s2 = W'($urandom);
    p1 = 1'($urandom); p2 = 1'($urandom);
    so1 = {w1, ^w1}; so2 = {w2, ^w2};
    si1 = {s1, p1};  si2 = {s2, p2};
    nframe = 0;
    @(negedge clk);
    b0.tx_valid = 1'b1;
    b0.tx_data  = w1;
    exp_q.push_back(mk_rx(s1, p1));
    for (int c = 1; c <= 2 * L + 2; c++) begin
      @(negedge clk);
      if (frame0) nframe++;
      if (c <= L) begin
        checks++;
        if ({frame0, so0} !== {1'b1, so1[W+1-c]}) begin
          errors++;
          $display("FAIL gap0_first cyc=%0d act frame=%b so=%b exp 1,%b", c, frame0, so0, so1[W+1-c]);
        end
        si0 = si1[W+1-c];
        b0.tx_data = w2;
      end else if (c == L + 1 || c == 2 * L + 2) begin
        checks++;
        if ({b0.rx_valid, b0.tx_ready} !== 2'b11) begin
          errors++;
          $display("FAIL gap0_rxrdy cyc=%0d act rxv=%b rdy=%b exp 1,1", c, b0.rx_valid, b0.tx_ready);
        end
        got = {b0.rx_data, b0.rx_perr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gap0_rx cyc=%0d act=%h exp=<queue empty>", c, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL gap0_rx cyc=%0d act data=%b perr=%b exp data=%b perr=%b", c, got.data, got.perr, e.data, e.perr);
          end
        end
        if (c == L + 1) exp_q.push_back(mk_rx(s2, p2));
        else b0.tx_valid = 1'b0;
      end else begin
        b0.tx_valid = 1'b0;
        checks++;
        if ({frame0, so0} !== {1'b1, so2[W+1-(c-L-1)]}) begin
          errors++;
          $display("FAIL gap0_second cyc=%0d act frame=%b so=%b exp 1,%b", c, frame0, so0, so2[W+1-(c-L-1)]);
        end
        si0 = si2[W+1-(c-L-1)];
      end
    end
    checks++;
    if (nframe != 2 * L) begin
      errors++;
      $display("FAIL gap0_frame_count act=%0d exp=%0d", nframe, 2 * L);
    end
  endtask

  // reset pulse in the second shift cycle discards the frame
  task automatic test_reset_mid();
    @(negedge clk);
    b1.tx_valid = 1'b1;
    b1.tx_data  = 4'hC;
    @(negedge clk);
    b1.tx_valid = 1'b0;
    si = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({frame, so, busy, b1.rx_valid, b1.rx_data, b1.tx_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_drop act frame=%b so=%b busy=%b rxv=%b rxd=%h rdy=%b exp all 0",
               frame, so, busy, b1.rx_valid, b1.rx_data, b1.tx_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < L + 2; c++) begin
      @(negedge clk);
      checks++;
      if ({b1.rx_valid, b1.rx_data, busy} !== '0) begin
        errors++;
        $display("FAIL midreset_norx cyc=%0d act rxv=%b rxd=%h busy=%b exp 0,0,0", c, b1.rx_valid, b1.rx_data, busy);
      end
    end
  endtask

  initial begin
    b1.tx_valid = 1'b0; b1.tx_data = '0; si = 1'b0;
    b0.tx_valid = 1'b0; b0.tx_data = '0; si0 = 1'b0;
    test_reset();
    test_frame(4'b1011, 4'b0110, 1'b0);
    test_back_to_back();
    test_gap0();
    test_frame(4'b1011, 4'b0110, 1'b1);
    test_frame(4'b1011, 4'b0110, 1'b0);
    test_reset_mid();
    test_frame(4'b0011, 4'b1110, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected act=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
